// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM encoding and default widths for the pe_mac_lanes block.
// Build option: define PE_REQUANT_EN to narrow lane outputs to DATA_WIDTH via shift/round/saturate.
`default_nettype none

package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } pe_state_t;

  localparam int PE_LANES      = 4;
  localparam int PE_DATA_WIDTH = 8;
  localparam int PE_WGT_WIDTH  = 8;
  localparam int PE_PSUM_WIDTH = 32;
  localparam int PE_BIAS_WIDTH = 16;
  localparam int PE_CNT_WIDTH  = 10;
  localparam int PE_SHIFT_W    = 5;

  // Per-lane output width depends on whether requantisation is built in.
  function automatic int pe_out_w(input int data_w, input int psum_w);
`ifdef PE_REQUANT_EN
    pe_out_w = data_w + (psum_w - psum_w);
`else
    pe_out_w = psum_w + (data_w - data_w);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_mac_lane.sv
// pe_mac_lane: one accumulator with extend/multiply/add, ReLU and optional requant.
// Build option: PE_REQUANT_EN selects the shift/round/saturate output stage.
`default_nettype none

module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int WGT_WIDTH  = PE_WGT_WIDTH,
  parameter int PSUM_WIDTH = PE_PSUM_WIDTH,
  parameter int BIAS_WIDTH = PE_BIAS_WIDTH,
  parameter int OUT_W      = pe_out_w(PE_DATA_WIDTH, PE_PSUM_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  beat_i,
  input  logic                  ia_sign_i,
  input  logic                  relu_i,
  input  logic [PE_SHIFT_W-1:0] shift_i,
  input  logic [DATA_WIDTH-1:0] ia_i,
  input  logic [WGT_WIDTH-1:0]  wgt_i,
  input  logic [BIAS_WIDTH-1:0] bias_i,
  output logic [OUT_W-1:0]      res_o
);

  localparam int PW = DATA_WIDTH + 1 + WGT_WIDTH;

  logic [PSUM_WIDTH-1:0] acc_q;
  logic [PSUM_WIDTH-1:0] acc_d;
  logic [DATA_WIDTH:0]   ia_ext;
  logic [PW-1:0]         ia_pw;
  logic [PW-1:0]         wgt_pw;
  logic [PW-1:0]         prod;
  logic [PSUM_WIDTH-1:0] prod_ext;
  logic [PSUM_WIDTH-1:0] bias_ext;
  logic [PSUM_WIDTH-1:0] relu_val;

  // Both operands widened to the full product width so the low PW bits are the exact signed product.
  assign ia_ext   = {ia_sign_i & ia_i[DATA_WIDTH-1], ia_i};
  assign ia_pw    = {{WGT_WIDTH{ia_ext[DATA_WIDTH]}}, ia_ext};
  assign wgt_pw   = {{(DATA_WIDTH+1){wgt_i[WGT_WIDTH-1]}}, wgt_i};
  assign prod     = ia_pw * wgt_pw;
  assign prod_ext = {{(PSUM_WIDTH-PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(PSUM_WIDTH-BIAS_WIDTH){bias_i[BIAS_WIDTH-1]}}, bias_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i)     acc_d = '0;
    else if (load_i) acc_d = bias_ext;
    else if (beat_i) acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign relu_val = (relu_i && acc_q[PSUM_WIDTH-1]) ? '0 : acc_q;

`ifdef PE_REQUANT_EN
  logic        [PSUM_WIDTH:0] rnd;
  logic signed [PSUM_WIDTH:0] sum;
  logic signed [PSUM_WIDTH:0] shr;
  logic                       fits;

  // One guard bit keeps the rounding add from wrapping before the shift.
  assign rnd  = (shift_i == '0) ? '0 : ({{PSUM_WIDTH{1'b0}}, 1'b1} << (shift_i - 5'd1));
  assign sum  = $signed({relu_val[PSUM_WIDTH-1], relu_val} + rnd);
  assign shr  = sum >>> shift_i;
  assign fits = (&shr[PSUM_WIDTH:DATA_WIDTH-1]) | ~(|shr[PSUM_WIDTH:DATA_WIDTH-1]);

  always_comb begin
    res_o = shr[OUT_W-1:0];
    if (!fits) res_o = shr[PSUM_WIDTH] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  logic unused_shift;
  assign unused_shift = ^shift_i;
  assign res_o        = relu_val;
`endif

endmodule

`default_nettype wire

// File: rtl/pe_mac_lanes.sv
// pe_mac_lanes: LANES parallel MACs sharing one broadcast activation, job FSM IDLE/ACC/OUT.
// Build option: PE_REQUANT_EN narrows each lane of out_data to DATA_WIDTH.
`default_nettype none

module pe_mac_lanes
  import pe_pkg::*;
#(
  parameter int LANES      = PE_LANES,
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int WGT_WIDTH  = PE_WGT_WIDTH,
  parameter int PSUM_WIDTH = PE_PSUM_WIDTH,
  parameter int BIAS_WIDTH = PE_BIAS_WIDTH,
  parameter int CNT_WIDTH  = PE_CNT_WIDTH
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic                                                   abort,
  input  logic [CNT_WIDTH-1:0]                                   cfg_len,
  input  logic                                                   cfg_ia_sign,
  input  logic                                                   cfg_relu,
  input  logic [PE_SHIFT_W-1:0]                                  cfg_shift,
  input  logic [LANES*BIAS_WIDTH-1:0]                            bias,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                                  ia,
  input  logic [LANES*WGT_WIDTH-1:0]                             wgt,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [LANES*pe_out_w(DATA_WIDTH, PSUM_WIDTH)-1:0]      out_data,
  output logic                                                   busy
);

  localparam int OUT_W = pe_out_w(DATA_WIDTH, PSUM_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  pe_state_t             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic                  sign_q, sign_d;
  logic                  relu_q, relu_d;
  logic [PE_SHIFT_W-1:0] shift_q, shift_d;
  logic                  load;
  logic                  beat;
  logic [LANES*OUT_W-1:0] lane_res;

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign load      = (state_q == IDLE) && start && !abort;
  assign beat      = in_valid && in_ready && !abort;
  // Blank the bus outside OUT so partial sums never leak.
  assign out_data  = out_valid ? lane_res : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sign_d  = sign_q;
    relu_d  = relu_q;
    shift_d = shift_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_d   = cfg_len;
            sign_d  = cfg_ia_sign;
            relu_d  = cfg_relu;
            shift_d = cfg_shift;
            cnt_d   = '0;
            state_d = (cfg_len == '0) ? OUT : ACC;
          end
        end
        ACC: begin
          if (beat) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q + CNT_ONE == len_q) state_d = OUT;
          end
        end
        OUT: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sign_q  <= 1'b0;
      relu_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sign_q  <= sign_d;
      relu_q  <= relu_d;
      shift_q <= shift_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .WGT_WIDTH  (WGT_WIDTH),
      .PSUM_WIDTH (PSUM_WIDTH),
      .BIAS_WIDTH (BIAS_WIDTH),
      .OUT_W      (OUT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (abort),
      .load_i    (load),
      .beat_i    (beat),
      .ia_sign_i (sign_q),
      .relu_i    (relu_q),
      .shift_i   (shift_q),
      .ia_i      (ia),
      .wgt_i     (wgt[g*WGT_WIDTH +: WGT_WIDTH]),
      .bias_i    (bias[g*BIAS_WIDTH +: BIAS_WIDTH]),
      .res_o     (lane_res[g*OUT_W +: OUT_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_mac_lanes.sv
// tb_pe_mac_lanes: directed self-checking bench for pe_mac_lanes (default build, plus requant vectors under PE_REQUANT_EN).
`default_nettype none

module tb_pe_mac_lanes;

`ifdef PE_REQUANT_EN
  localparam int OUT_W = 8;
`else
  localparam int OUT_W = 32;
`endif
  localparam int LANES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [9:0]        cfg_len = '0;
  logic              cfg_ia_sign = 1'b0;
  logic              cfg_relu = 1'b0;
  logic [4:0]        cfg_shift = '0;
  logic [63:0]       bias = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        ia = '0;
  logic [31:0]       wgt = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LANES*OUT_W-1:0] out_data;
  logic              busy;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  pe_mac_lanes dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_ia_sign(cfg_ia_sign), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .ia(ia), .wgt(wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a job, then scramble cfg_* so any late sampling shows up in the results.
  task automatic start_job(input logic [9:0] len, input logic sgn, input logic rl,
                           input logic [4:0] sh, input logic [63:0] b);
    cfg_len = len; cfg_ia_sign = sgn; cfg_relu = rl; cfg_shift = sh; bias = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_len = 10'h3FF; cfg_ia_sign = ~sgn; cfg_relu = ~rl; cfg_shift = sh + 5'd3;
    bias = ~b;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic one_beat(input logic [7:0] a, input logic [31:0] w);
    in_valid = 1'b1; ia = a; wgt = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit quiet;
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_data !== '0) begin errs++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    reset = 1'b1;
    tick();
    // Asynchronous reset in the middle of an accumulation.
    start_job(10'd3, 1'b0, 1'b0, 5'd0, 64'd7);
    one_beat(8'd9, 32'h01010101);
    #3 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      begin errs++; $display("FAIL midreset_ctrl got busy=%b ov=%b ir=%b want 0 0 0", busy, out_valid, in_ready); end
    checks++; if (out_data !== '0) begin errs++; $display("FAIL midreset_data got=%h want=0", out_data); end
    tick();
    reset = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; ia = 8'd1;
      if (out_valid || busy) quiet = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (quiet !== 1'b1) begin errs++; $display("FAIL post_reset_idle got=%b want=1", quiet); end
  endtask

`ifndef PE_REQUANT_EN
  task automatic test_basic();
    bit ok;
    logic [127:0] exp_d;
    exp_d = {32'd9, 32'd4, 32'd9, 32'd19};
    start_job(10'd3, 1'b0, 1'b0, 5'd0, {16'd0, 16'hFFFB, 16'd0, 16'd10});
    wgt = 32'h01010101;
    in_valid = 1'b1;
    ia = 8'd2; tick();
    ia = 8'd3; tick();
    ia = 8'd4; tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_latency out_valid got=%b want=1", out_valid); end
    wait_out(ok);
    checks++; if (!ok) begin errs++; $display("FAIL basic_timeout got=0 want=1"); end
    checks++; if (out_data !== exp_d) begin errs++; $display("FAIL basic_data got=%h want=%h", out_data, exp_d); end
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_data !== exp_d)
      begin errs++; $display("FAIL basic_hold got ov=%b d=%h want 1 %h", out_valid, out_data, exp_d); end
    // Start coinciding with the output handshake must be dropped.
    start = 1'b1; cfg_len = 10'd0; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      begin errs++; $display("FAIL basic_release got busy=%b ov=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_sign_relu();
    bit ok;
    logic [31:0] w;
    logic [127:0] exp_d;
    w = {8'hFD, 8'd5, 8'd5, 8'd5};
    start_job(10'd1, 1'b1, 1'b0, 5'd0, 64'd0);
    one_beat(8'hFF, w);
    wait_out(ok);
    exp_d = {32'd3, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB};
    checks++; if (!ok || out_data !== exp_d) begin errs++; $display("FAIL signed_mul got=%h want=%h", out_data, exp_d); end
    pop(); tick();
    start_job(10'd1, 1'b1, 1'b1, 5'd0, 64'd0);
    one_beat(8'hFF, w);
    wait_out(ok);
    exp_d = {32'd3, 32'd0, 32'd0, 32'd0};
    checks++; if (!ok || out_data !== exp_d) begin errs++; $display("FAIL relu got=%h want=%h", out_data, exp_d); end
    pop(); tick();
    start_job(10'd1, 1'b0, 1'b0, 5'd0, 64'd0);
    one_beat(8'hFF, w);
    wait_out(ok);
    exp_d = {32'hFFFFFD03, 32'd1275, 32'd1275, 32'd1275};
    checks++; if (!ok || out_data !== exp_d) begin errs++; $display("FAIL unsigned_mul got=%h want=%h", out_data, exp_d); end
    pop(); tick();
  endtask

  task automatic test_backpressure();
    int acc_n;
    logic [7:0] nxt;
    bit stable;
    logic [127:0] exp_d;
    exp_d = {32'd24, 32'd18, 32'd12, 32'd6};
    start_job(10'd3, 1'b0, 1'b0, 5'd0, 64'd0);
    wgt = {8'd4, 8'd3, 8'd2, 8'd1};
    acc_n = 0; nxt = 8'd1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      ia = nxt;
      if (in_valid && in_ready) begin acc_n++; nxt = nxt + 8'd1; end
      tick();
    end
    checks++; if (acc_n !== 3) begin errs++; $display("FAIL bp_beats got=%0d want=3", acc_n); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
      begin errs++; $display("FAIL bp_out_state got ir=%b ov=%b want 0 1", in_ready, out_valid); end
    in_valid = 1'b0;
    checks++; if (out_data !== exp_d) begin errs++; $display("FAIL bp_data got=%h want=%h", out_data, exp_d); end
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; ia = 8'd50;
      tick();
      if (out_data !== exp_d || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (stable !== 1'b1) begin errs++; $display("FAIL bp_stable got=%h want=%h", out_data, exp_d); end
    pop(); tick();
  endtask

  task automatic test_boundaries();
    bit ok;
    logic [127:0] exp_d;
    // Zero-length job goes straight to OUT with the bias.
    start_job(10'd0, 1'b0, 1'b0, 5'd0, {16'd4, 16'd3, 16'd2, 16'hFFFF});
    exp_d = {32'd4, 32'd3, 32'd2, 32'hFFFFFFFF};
    checks++; if (out_valid !== 1'b1 || out_data !== exp_d)
      begin errs++; $display("FAIL len0 got ov=%b d=%h want 1 %h", out_valid, out_data, exp_d); end
    pop(); tick();
    // Start during ACC is ignored.
    start_job(10'd2, 1'b0, 1'b0, 5'd0, 64'd0);
    one_beat(8'd7, 32'h01010101);
    cfg_len = 10'd0; bias = {16'd99, 16'd99, 16'd99, 16'd99};
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errs++; $display("FAIL start_in_acc got ir=%b ov=%b want 1 0", in_ready, out_valid); end
    one_beat(8'd8, 32'h01010101);
    wait_out(ok);
    exp_d = {32'd15, 32'd15, 32'd15, 32'd15};
    checks++; if (!ok || out_data !== exp_d) begin errs++; $display("FAIL start_in_acc_data got=%h want=%h", out_data, exp_d); end
    // Abort dominates handshake and start while output is pending.
    abort = 1'b1; out_ready = 1'b1; start = 1'b1; cfg_len = 10'd0;
    tick();
    abort = 1'b0; out_ready = 1'b0; start = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0)
      begin errs++; $display("FAIL abort_out got ov=%b busy=%b d=%h want 0 0 0", out_valid, busy, out_data); end
    // Abort mid-accumulation, then a clean job.
    start_job(10'd2, 1'b0, 1'b0, 5'd0, 64'd0);
    one_beat(8'd5, 32'h01010101);
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_acc busy got=%b want=0", busy); end
    start_job(10'd2, 1'b0, 1'b0, 5'd0, 64'd0);
    one_beat(8'd1, 32'h04030201);
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL abort_cnt_clear early out got=%b want=0", out_valid); end
    one_beat(8'd2, 32'h04030201);
    wait_out(ok);
    exp_d = {32'd12, 32'd9, 32'd6, 32'd3};
    checks++; if (!ok || out_data !== exp_d) begin errs++; $display("FAIL after_abort got=%h want=%h", out_data, exp_d); end
    pop(); tick();
  endtask
`else
  task automatic test_requant();
    bit ok;
    logic [31:0] exp_d;
    start_job(10'd0, 1'b0, 1'b0, 5'd1, {16'd0, 16'd300, 16'd5, 16'hFED4});
    wait_out(ok);
    exp_d = {8'd0, 8'd127, 8'd3, 8'h80};
    checks++; if (!ok || out_data !== exp_d) begin errs++; $display("FAIL requant_sh1 got=%h want=%h", out_data, exp_d); end
    pop(); tick();
    start_job(10'd0, 1'b0, 1'b0, 5'd0, {16'd0, 16'd300, 16'd5, 16'hFED4});
    wait_out(ok);
    exp_d = {8'd0, 8'd127, 8'd5, 8'h80};
    checks++; if (!ok || out_data !== exp_d) begin errs++; $display("FAIL requant_sh0 got=%h want=%h", out_data, exp_d); end
    pop(); tick();
    start_job(10'd1, 1'b0, 1'b0, 5'd2, 64'd0);
    one_beat(8'd10, {8'd1, 8'd2, 8'd3, 8'hFB});
    wait_out(ok);
    exp_d = {8'd3, 8'd5, 8'd8, 8'hF4};
    checks++; if (!ok || out_data !== exp_d) begin errs++; $display("FAIL requant_mac got=%h want=%h", out_data, exp_d); end
    pop(); tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef PE_REQUANT_EN
    test_requant();
`else
    test_basic();
    test_sign_relu();
    test_backpressure();
    test_boundaries();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pe_mac_lanes.md
PE_MAC_LANES -- requirements
Module: pe_mac_lanes

Interface
REQ-001 SHALL have parameter LANES, 4, number of parallel MAC lanes sharing one broadcast activation.
REQ-002 SHALL have parameter DATA_WIDTH, 8, activation width.
REQ-003 SHALL have parameter WGT_WIDTH, 8, per-lane weight width.
REQ-004 SHALL have parameters PSUM_WIDTH, 32, accumulator width; BIAS_WIDTH, 16, per-lane bias width; CNT_WIDTH, 10, beat-count width.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports start  input  1  job start pulse; abort  input  1  synchronous job cancel.
REQ-008 SHALL have ports cfg_len  input  CNT_WIDTH  MAC beats per job; cfg_ia_sign  input  1  activation signed; cfg_relu  input  1  ReLU enable; cfg_shift  input  5  requant shift.
REQ-009 SHALL have port bias  input  LANES*BIAS_WIDTH  per-lane bias, lane 0 in LSBs.
REQ-010 SHALL have ports in_valid  input  1; in_ready  output  1; ia  input  DATA_WIDTH; wgt  input  LANES*WGT_WIDTH  lane 0 in LSBs.
REQ-011 SHALL have ports out_valid  output  1; out_ready  input  1; out_data  output  LANES*OUT_W  (OUT_W per REQ-025/026); busy  output  1  state != IDLE.

Function
REQ-012 SHALL implement FSM IDLE, ACC, OUT.
REQ-013 IDLE: start=1 SHALL latch cfg_* into shadow registers, load each lane accumulator with sign-extended bias, clear beat counter, go to ACC (or OUT if cfg_len=0).
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 ACC: in_ready SHALL be 1; a beat is accepted when in_valid&in_ready; in_ready SHALL be 0 in IDLE and OUT.
REQ-016 per accepted beat, each lane SHALL add product to accumulator in the same edge: zero cycle bubble, one beat per clock sustained.
REQ-017 product: ia extended to DATA_WIDTH+1 (sign-extend if latched cfg_ia_sign else zero-extend), signed multiply by signed lane weight, sign-extended to PSUM_WIDTH.
REQ-018 accumulation SHALL wrap modulo 2^PSUM_WIDTH, no saturation.
REQ-019 beat counter SHALL increment per accepted beat; on the beat making count = latched cfg_len, FSM SHALL go to OUT next edge.
REQ-020 OUT: out_valid=1, out_data stable until out_valid&out_ready; on that edge FSM SHALL go to IDLE; start on same edge is ignored (one idle cycle minimum between jobs).
REQ-021 ReLU (latched cfg_relu=1): negative lane result SHALL be output as 0; applied per lane before requant.
REQ-022 abort=1 SHALL force IDLE next edge from any state, drop out_valid, clear counter and accumulators; abort dominates start and handshakes on same edge.
REQ-023 cfg_* SHALL not affect an in-flight job after latching.

Reset
REQ-024 reset low SHALL immediately force IDLE, accumulators 0, counter 0, shadow cfg 0, in_ready=0, out_valid=0, busy=0, out_data=0; mid-job state is discarded.

Configuration
REQ-025 with PE_REQUANT_EN defined: OUT_W=DATA_WIDTH; each lane result arithmetic-shifted right by latched cfg_shift with round-half-up (add 2^(shift-1) when shift>0), then saturated to signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; cfg_shift port SHALL exist.
REQ-026 without PE_REQUANT_EN: OUT_W=PSUM_WIDTH, raw (ReLU'd) accumulator output, cfg_shift port still present but ignored.

Structure
REQ-027 shared package pe_pkg SHALL hold FSM state encoding constants (IDLE=0, ACC=1, OUT=2) and default width constants.
REQ-028 one sub-module pe_mac_lane SHALL hold one accumulator, extend/multiply/add, ReLU and optional requant; instantiated LANES times via generate.

Verification
REQ-029 reset: drive reset low mid-ACC -> busy=0, out_valid=0, out_data=0 same cycle, no output after release.
REQ-030 basic: LANES=4, bias={10,0,-5,0}, cfg_len=3, ia=2,3,4 unsigned, wgt all lanes=1 -> raw results {19,9,4,9}, out_valid held until out_ready.
REQ-031 sign/ReLU: cfg_ia_sign=1, ia=0xFF(-1), wgt=5, len=1, bias 0 -> -5; with cfg_relu=1 -> 0; with cfg_ia_sign=0 -> 1275.
REQ-032 backpressure: in_valid toggled 1/0, out_ready low 4 cycles -> exactly cfg_len beats accepted, out_data stable, in_ready=0 in OUT.
REQ-033 boundaries: cfg_len=0 -> OUT with bias only; start during ACC ignored; abort with out_valid=1 -> IDLE, no transfer.
REQ-034 PE_REQUANT_EN: accumulator 300, shift=1 -> 127 saturated; 5, shift=1 -> 3; -300, shift=0 -> -128.
